// File: rtl/step_sequencer.sv
// Timed half-step phase sequencer for a 4-phase unipolar stepper: counts clock
// cycles per step, walks an 8-entry coil table and tracks signed position.
module step_sequencer #(
  parameter int unsigned PERIOD_W = 32,
  parameter int unsigned POS_W    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [PERIOD_W-1:0] cycles,
  input  logic                dir,
  input  logic                full_step,
  output logic [3:0]          coils,
  output logic                step_pulse,
  output logic                running,
  output logic [POS_W-1:0]    position
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t              state;
  logic [2:0]          phase;
  logic [PERIOD_W-1:0] counter;
  logic [PERIOD_W-1:0] period_q;

  logic [2:0]       step_sz;
  logic [2:0]       phase_nxt;
  logic [POS_W-1:0] pos_nxt;
  logic [3:0]       pattern;

  // Next phase/position for a step in the currently requested direction and mode
  always_comb begin
    step_sz   = full_step ? 3'd2 : 3'd1;
    phase_nxt = dir ? (phase + step_sz) : (phase - step_sz);
    pos_nxt   = dir ? (position + POS_W'(step_sz)) : (position - POS_W'(step_sz));
  end

  // Half-step coil table, bit3 = coil A
  always_comb begin
    pattern = 4'b0000;
    case (phase)
      3'd0: pattern = 4'b1000;
      3'd1: pattern = 4'b1100;
      3'd2: pattern = 4'b0100;
      3'd3: pattern = 4'b0110;
      3'd4: pattern = 4'b0010;
      3'd5: pattern = 4'b0011;
      3'd6: pattern = 4'b0001;
      3'd7: pattern = 4'b1001;
      default: pattern = 4'b0000;
    endcase
  end

  // Coils release in the same cycle en falls, and immediately on reset
  assign coils = (en && !rst) ? pattern : 4'b0000;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      phase      <= 3'd0;
      counter    <= '0;
      period_q   <= '0;
      step_pulse <= 1'b0;
      running    <= 1'b0;
      position   <= '0;
    end else begin
      step_pulse <= 1'b0;
      case (state)
        IDLE: begin
          counter <= '0;
          running <= 1'b0;
          if (en && (cycles != '0)) begin
            period_q <= cycles;
            counter  <= PERIOD_W'(1);
            state    <= RUN;
            running  <= 1'b1;
          end
        end
        RUN: begin
          if (!en) begin
            // Disable wins over a coincident step boundary
            state   <= IDLE;
            running <= 1'b0;
            counter <= '0;
          end else if (counter == period_q) begin
            phase      <= phase_nxt;
            position   <= pos_nxt;
            step_pulse <= 1'b1;
            counter    <= PERIOD_W'(1);
            period_q   <= cycles;
            if (cycles == '0) begin
              state   <= IDLE;
              running <= 1'b0;
              counter <= '0;
            end
          end else begin
            counter <= counter + PERIOD_W'(1);
          end
        end
        default: begin
          state   <= IDLE;
          running <= 1'b0;
          counter <= '0;
        end
      endcase
    end
  end

endmodule
